// File: rtl/dec_ren_queue.sv
// ---------------------------------------------------------------------------
// dec_ren_queue : in-order elastic micro-op buffer between decode and rename
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dec_ren_queue #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes depend only on registered occupancy: no out_ready->in_ready path.
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign in_ready  = en & ~full & ~flush;
  assign out_valid = en & ~empty & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (en && flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dec_ren_queue.sv
// ---------------------------------------------------------------------------
// tb_dec_ren_queue : DEPTH=4 and DEPTH=3 queues driven in lockstep vs queue model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dec_ren_queue;

  localparam int W = 96;

  logic         clk = 1'b0;
  logic         rst, en, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         ir4, ov4, e4, f4;
  logic [W-1:0] od4;
  logic [2:0]   count4;
  logic         ir3, ov3, e3, f3;
  logic [W-1:0] od3;
  logic [1:0]   count3;

  int nchk  = 0;
  int nfail = 0;

  logic [W-1:0] m4 [$];
  logic [W-1:0] m3 [$];

  always #5 clk = ~clk;

  dec_ren_queue #(.WIDTH(W), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_ready(out_ready),
    .count(count4), .empty(e4), .full(f4)
  );

  dec_ren_queue #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(out_ready),
    .count(count3), .empty(e3), .full(f3)
  );

  function automatic int msize(int k);
    return (k == 1) ? m3.size() : m4.size();
  endfunction

  function automatic int mdepth(int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic logic [W-1:0] mfront(int k);
    if (k == 1 && m3.size() > 0) return m3[0];
    if (k == 0 && m4.size() > 0) return m4[0];
    return '0;
  endfunction

  // {in_ready, out_valid, full, empty, count[3:0], out_data}
  function automatic logic [W+7:0] exp_vec(int k);
    logic ir, ov;
    ir = (en === 1'b1) && (msize(k) < mdepth(k)) && (flush === 1'b0);
    ov = (en === 1'b1) && (msize(k) > 0) && (flush === 1'b0);
    return {ir, ov, msize(k) == mdepth(k), msize(k) == 0, 4'(msize(k)),
            ov ? mfront(k) : {W{1'b0}}};
  endfunction

  function automatic logic [W+7:0] obs_vec(int k);
    if (k == 1) return {ir3, ov3, f3, e3, 4'(count3), od3};
    return {ir4, ov4, f4, e4, 4'(count4), od4};
  endfunction

  // Advance one clock; the model applies the same edge using the queue rules.
  task automatic step();
    bit p;
    @(posedge clk);
    if (rst) begin
      m4.delete();
      m3.delete();
    end else if (en) begin
      if (flush) begin
        m4.delete();
        m3.delete();
      end else begin
        p = (m4.size() < 4) && in_valid;
        if (m4.size() > 0 && out_ready) void'(m4.pop_front());
        if (p) m4.push_back(in_data);
        p = (m3.size() < 3) && in_valid;
        if (m3.size() > 0 && out_ready) void'(m3.pop_front());
        if (p) m3.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic push_n(int n, logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; out_ready = 1'b0; in_data = base + W'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    push_n(2, W'('h55));
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_data = {$urandom(), $urandom(), $urandom()};
    step();
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    nchk++;
    if (od4 !== '0 || ov4 !== 1'b0) begin
      nfail++; $display("FAIL reset_out got ov=%b data=%h want ov=0 data=0", ov4, od4);
    end
    nchk++;
    if ({e4, f4, ir4, count4} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      nfail++; $display("FAIL reset_flags got e/f/ir/cnt=%b%b%b%0d want 1 0 1 0", e4, f4, ir4, count4);
    end
    for (int k = 0; k < 2; k++) begin
      nchk++;
      if (obs_vec(k) !== exp_vec(k)) begin
        nfail++; $display("FAIL reset_vec dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_push_three();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; out_ready = 1'b0; in_data = W'('hA1 + i);
      @(negedge clk);
      nchk++;
      if (count4 !== 3'(i)) begin
        nfail++; $display("FAIL push3_cnt[%0d] got %0d want %0d", i, count4, i);
      end
      if (i > 0) begin
        nchk++;
        if (od4 !== W'('hA1)) begin
          nfail++; $display("FAIL push3_head[%0d] got %h want a1", i, od4);
        end
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    nchk++;
    if ({count4, f4, ir4} !== {3'd3, 1'b0, 1'b1} || od4 !== W'('hA1)) begin
      nfail++; $display("FAIL push3_end got cnt=%0d f=%b ir=%b data=%h want 3 0 1 a1", count4, f4, ir4, od4);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; out_ready = 1'b0; in_data = W'(i + 1);
      @(negedge clk);
      if (i == 4) begin
        nchk++;
        if (ir4 !== 1'b0 || f4 !== 1'b1) begin
          nfail++; $display("FAIL ovf_refuse got ir=%b full=%b want 0 1", ir4, f4);
        end
      end
      for (int k = 0; k < 2; k++) begin
        nchk++;
        if (obs_vec(k) !== exp_vec(k)) begin
          nfail++; $display("FAIL ovf_fill dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nchk++;
      if (ov4 !== 1'b1 || od4 !== W'(i + 1)) begin
        nfail++; $display("FAIL ovf_drain[%0d] got ov=%b data=%h want 1 %0h", i, ov4, od4, i + 1);
      end
      step();
    end
    @(negedge clk);
    nchk++;
    if (e4 !== 1'b1 || od4 !== '0) begin
      nfail++; $display("FAIL ovf_empty got e=%b data=%h want 1 0", e4, od4);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_n(2, W'(100));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = W'(102 + i);
      @(negedge clk);
      nchk++;
      if (count4 !== 3'd2 || count3 !== 2'd2) begin
        nfail++; $display("FAIL b2b_cnt[%0d] got %0d/%0d want 2/2", i, count4, count3);
      end
      nchk++;
      if (od4 !== W'(100 + i) || od3 !== W'(100 + i)) begin
        nfail++; $display("FAIL b2b_order[%0d] got %0d/%0d want %0d", i, od4, od3, 100 + i);
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [W-1:0] x;
    x = {$urandom(), $urandom(), $urandom()};
    do_reset();
    push_n(3, W'('h300));
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = W'('hBAD);
    @(negedge clk);
    nchk++;
    if ({ir4, ov4, ir3, ov3} !== 4'b0000 || od4 !== '0) begin
      nfail++; $display("FAIL flush_cycle got ir/ov=%b%b%b%b data=%h want 0000 0", ir4, ov4, ir3, ov3, od4);
    end
    step();
    flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = x;
    @(negedge clk);
    nchk++;
    if (count4 !== 3'd0 || e4 !== 1'b1 || od4 !== '0 || count3 !== 2'd0) begin
      nfail++; $display("FAIL flush_after got cnt=%0d e=%b data=%h want 0 1 0", count4, e4, od4);
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    nchk++;
    if (ov4 !== 1'b1 || od4 !== x || count4 !== 3'd1) begin
      nfail++; $display("FAIL flush_repush got ov=%b data=%h cnt=%0d want 1 %h 1", ov4, od4, count4, x);
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] d0;
    d0 = {$urandom(), $urandom(), $urandom()};
    do_reset();
    push_n(1, d0);
    push_n(1, ~d0);
    for (int i = 0; i < 3; i++) begin
      en = 1'b0; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      in_data = {$urandom(), $urandom(), $urandom()};
      @(negedge clk);
      nchk++;
      if (ir4 !== 1'b0 || ov4 !== 1'b0 || count4 !== 3'd2 || od4 !== '0) begin
        nfail++; $display("FAIL en_freeze[%0d] got ir=%b ov=%b cnt=%0d data=%h want 0 0 2 0", i, ir4, ov4, count4, od4);
      end
      step();
    end
    en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    nchk++;
    if (ov4 !== 1'b1 || od4 !== d0 || count4 !== 3'd2 || od3 !== d0) begin
      nfail++; $display("FAIL en_resume got ov=%b data=%h cnt=%0d want 1 %h 2", ov4, od4, count4, d0);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    push_n(4, W'('h400));
    in_valid = 1'b1; out_ready = 1'b1; in_data = W'('h404);
    @(negedge clk);
    nchk++;
    if (ir4 !== 1'b0 || ov4 !== 1'b1 || count4 !== 3'd4) begin
      nfail++; $display("FAIL fullpop_1 got ir=%b ov=%b cnt=%0d want 0 1 4", ir4, ov4, count4);
    end
    step();
    @(negedge clk);
    nchk++;
    if (count4 !== 3'd3 || ir4 !== 1'b1 || od4 !== W'('h401)) begin
      nfail++; $display("FAIL fullpop_2 got cnt=%0d ir=%b data=%h want 3 1 401", count4, ir4, od4);
    end
    step();
    @(negedge clk);
    nchk++;
    if (count4 !== 3'd3 || od4 !== W'('h402)) begin
      nfail++; $display("FAIL fullpop_3 got cnt=%0d data=%h want 3 402", count4, od4);
    end
    for (int k = 0; k < 2; k++) begin
      nchk++;
      if (obs_vec(k) !== exp_vec(k)) begin
        nfail++; $display("FAIL fullpop_vec dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      en        = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      in_data   = {$urandom(), $urandom(), $urandom()};
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        nchk++;
        if (obs_vec(k) !== exp_vec(k)) begin
          nfail++; $display("FAIL rand[%0d] dut%0d got %h want %h", i, k, obs_vec(k), exp_vec(k));
        end
      end
      step();
    end
    rst = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0;
    #1;
    step();
    test_reset();
    test_push_three();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_enable();
    test_full_pop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/dec_ren_queue.md
Name: dec_ren_queue

Overview:
- Parametrised elastic buffer between decode and rename; successor to the single-entry decode/rename pipeline register.
- Holds up to DEPTH decoded micro-op payloads in order, with valid/ready handshakes on both sides instead of a global stall.
- Provides a whole-queue flush on redirect, plus a global enable freeze.
- Drives zero payload whenever no valid entry is presented, so rename sees an inert bubble.

Parameters:
- WIDTH, 96, payload width in bits (PC, inst, opcode, FU type, control fields, concatenated by the decode stage).
- DEPTH, 4, number of entries; any integer >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- en  input  1  global enable; 0 freezes all state and blocks both handshakes
- flush  input  1  discard all entries (branch/exception redirect)
- in_valid  input  1  decode presents a payload
- in_data  input  WIDTH  decode payload
- in_ready  output  1  queue can accept this cycle
- out_valid  output  1  head entry presented to rename
- out_data  output  WIDTH  head payload; all zeros when out_valid=0
- out_ready  input  1  rename accepts head this cycle
- count  output  CNT_W  current occupancy, 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- On rst: wr_ptr=0, rd_ptr=0, count=0. All storage entries are zeroed.
- Outputs after rst: out_valid=0, out_data=0, empty=1, full=0, in_ready=1 (when en=1).
- Handshake combinational outputs:
  - in_ready = en & ~full & ~flush.
  - out_valid = en & ~empty & ~flush.
- Fire conditions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- There is no combinational path from out_ready to in_ready. A full queue refuses a push even if it pops in the same cycle.
- Latency: a payload pushed at edge N is at out_data in cycle N+1 at the earliest, if the queue was empty. There is no empty bypass.
- push only: store in_data at wr_ptr, advance wr_ptr, count+1.
- pop only: advance rd_ptr, count-1.
- push and pop together (queue neither empty nor full): both pointers advance, count unchanged, ordering preserved.
- Pointer wrap: ptr = (ptr==DEPTH-1) ? 0 : ptr+1. Non-power-of-two DEPTH must work.
- flush (with en=1):
  - Next edge: wr_ptr=0, rd_ptr=0, count=0, all entries zeroed.
  - Beats are neither accepted nor presented in the flush cycle.
  - flush has priority over push and pop.
- en=0: pointers, count and storage hold; in_ready=0, out_valid=0, out_data=0.
- flush and rst are ignored while en=0, except rst, which always wins.
- out_data = entry[rd_ptr] when out_valid, else 0. No X may propagate.
- count, empty and full are registered state decoded combinationally. They reflect the held values during en=0.
- Overflow and underflow are impossible by construction.
- Reset or flush mid-stream drops all in-flight entries. There is no partial retention.

Test Plan:
- Reset, then push 0xA1, 0xA2, 0xA3 on consecutive cycles with out_ready=0 -> count 1,2,3. out_data=0xA1 from the cycle after the first push. full=0, in_ready=1.
- DEPTH=4: push 5 beats with out_ready=0 -> 4 accepted, full=1, in_ready=0 on the 5th. Then out_ready=1 for 4 cycles -> out_data sequence 1,2,3,4, then empty=1, out_data=0.
- Count at 2, in_valid=1, out_ready=1 for 10 cycles with incrementing data -> count stays 2. Output order matches input order across two pointer wraps. Repeat with DEPTH=3.
- Count 3, assert flush with in_valid=1, out_ready=1 -> no push or pop that cycle. Next cycle count=0, empty=1, out_data=0. A push in the following cycle is then visible one cycle later.
- Count 2, en=0 for 3 cycles with in_valid=1, out_ready=1 and flush=1 -> in_ready=0, out_valid=0, count stays 2. After en=1, the original head is presented unchanged.
- Full queue, in_valid=1, out_ready=1 -> pop occurs, push refused (in_ready=0), count 4->3. Next cycle the push is accepted together with a pop, count stays 3.
